// File: rtl/ram_loader.sv
// ram_loader: packs a little-endian byte stream into 32-bit words, writes them
// to consecutive RAM word addresses from BASE_ADDR, and optionally reads the
// region back to compare a mod-2^32 checksum.
module ram_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned MAX_WORDS = 4096,
  parameter int unsigned VERIFY    = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [15:0] word_cnt_i,
  input  logic        s_valid_i,
  input  logic [7:0]  s_data_i,
  output logic        s_ready_o,
  output logic        ram_wr_en_o,
  output logic [31:0] ram_wr_addr_o,
  output logic [31:0] ram_wr_data_o,
  output logic [31:0] ram_rd_addr_o,
  input  logic [31:0] ram_rd_data_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        error_o,
  output logic [31:0] checksum_o
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LOAD  = 3'd1;
  localparam logic [2:0] ST_WRITE = 3'd2;
  localparam logic [2:0] ST_RD    = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  logic [2:0]  r_state;
  logic [15:0] r_cnt;
  logic [15:0] r_i;
  logic [15:0] r_j;
  logic [1:0]  r_b;
  logic [23:0] r_word;
  logic [31:0] r_sum;
  logic [31:0] r_rsum;
  logic        r_err;
  logic        r_ready;
  logic        r_busy;
  logic        r_done;
  logic        r_wr_en;
  logic [31:0] r_wr_addr;
  logic [31:0] r_wr_data;
  logic [31:0] r_rd_addr;

  logic [2:0]  w_next;
  logic        w_hs;
  logic        w_last_word;
  logic        w_oversize;
  logic [31:0] w_wr_addr;

  assign w_hs        = s_valid_i & r_ready;
  assign w_last_word = (r_i == (r_cnt - 16'd1));
  assign w_oversize  = ({16'd0, word_cnt_i} > MAX_WORDS);
  assign w_wr_addr   = BASE_ADDR + {14'd0, r_i, 2'b00};

  // Next-state decision for the load / write / read-back sequence.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (start_i) begin
          if (word_cnt_i == 16'd0 || w_oversize) w_next = ST_DONE;
          else                                   w_next = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (w_hs && r_b == 2'd3) w_next = ST_WRITE;
      end
      ST_WRITE: begin
        if (w_last_word) w_next = (VERIFY != 0) ? ST_RD : ST_DONE;
        else             w_next = ST_LOAD;
      end
      ST_RD: begin
        if (r_j == r_cnt) w_next = ST_DONE;
      end
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // State, datapath and registered outputs; outputs track the state being entered.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_i       <= '0;
      r_j       <= '0;
      r_b       <= '0;
      r_word    <= '0;
      r_sum     <= '0;
      r_rsum    <= '0;
      r_err     <= 1'b0;
      r_ready   <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
      r_rd_addr <= '0;
    end else begin
      r_state <= w_next;
      r_ready <= (w_next == ST_LOAD);
      r_busy  <= (w_next == ST_LOAD) || (w_next == ST_WRITE) || (w_next == ST_RD);
      r_done  <= (w_next == ST_DONE);
      r_wr_en <= (w_next == ST_WRITE);
      case (r_state)
        ST_IDLE: begin
          if (start_i) begin
            r_cnt <= word_cnt_i;
            r_err <= w_oversize;
            r_sum <= '0;
            r_i   <= '0;
            r_b   <= '0;
          end
        end
        ST_LOAD: begin
          if (w_hs) begin
            r_b <= r_b + 2'd1;
            case (r_b)
              2'd0: r_word[7:0]   <= s_data_i;
              2'd1: r_word[15:8]  <= s_data_i;
              2'd2: r_word[23:16] <= s_data_i;
              default: begin
                r_wr_addr <= w_wr_addr;
                r_wr_data <= {s_data_i, r_word};
              end
            endcase
          end
        end
        ST_WRITE: begin
          r_sum <= r_sum + r_wr_data;
          r_i   <= r_i + 16'd1;
          if (w_last_word && VERIFY != 0) begin
            r_rd_addr <= BASE_ADDR;
            r_j       <= '0;
            r_rsum    <= '0;
          end
        end
        ST_RD: begin
          // Cycle j issues address j (j < count) and accumulates data for address j-1.
          r_j <= r_j + 16'd1;
          if (r_j != 16'd0) r_rsum <= r_rsum + ram_rd_data_i;
          if ((r_j + 16'd1) < r_cnt) r_rd_addr <= r_rd_addr + 32'd4;
          if (r_j == r_cnt && (r_rsum + ram_rd_data_i) != r_sum) r_err <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign s_ready_o     = r_ready;
  assign ram_wr_en_o   = r_wr_en;
  assign ram_wr_addr_o = r_wr_addr;
  assign ram_wr_data_o = r_wr_data;
  assign ram_rd_addr_o = r_rd_addr;
  assign busy_o        = r_busy;
  assign done_o        = r_done;
  assign error_o       = r_err;
  assign checksum_o    = r_sum;

endmodule
